// File: rtl/cpu_axil_pkg.sv
// Shared types and constants for the CPU-to-AXI-Lite bridge.
package cpu_axil_pkg;

  // Bridge sequencing; exactly one transaction is in flight at a time.
  typedef enum logic [2:0] {
    StIdle,
    StWrAddrData,
    StWrResp,
    StRdAddr,
    StRdData,
    StDone
  } state_e;

  // AXI response codes.
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExokay = 2'b01;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  // AXI protection encodings: unprivileged, secure, data or instruction.
  localparam logic [2:0] ProtData  = 3'b000;
  localparam logic [2:0] ProtInstr = 3'b100;

  // Read-channel protection for a request; bit 2 flags an instruction fetch.
  function automatic logic [2:0] rd_prot(input logic instr);
    return instr ? ProtInstr : ProtData;
  endfunction

endpackage

// File: rtl/cpu_axil_master.sv
// Bridges a simple valid/ready CPU memory port onto an AXI-Lite master.
module cpu_axil_master
  import cpu_axil_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // CPU side
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [STRB_WIDTH-1:0] mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_error,
  // Write address channel
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  // Write data channel
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  // Write response channel
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  // Read address channel
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  // Read data channel
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    instr_q, instr_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  // Next-state and next-output logic; every handshake flag is registered.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    instr_d   = instr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = 1'b0;
    arvalid_d = arvalid_q;
    rready_d  = 1'b0;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    rdata_d   = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          if (|mem_wstrb) begin
            state_d   = StWrAddrData;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRdAddr;
            arvalid_d = 1'b1;
          end
        end
      end
      StWrAddrData: begin
        // Each channel retires on its own handshake; order does not matter.
        if (m_axil_awready) awvalid_d = 1'b0;
        if (m_axil_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = StWrResp;
          bready_d = 1'b1;
        end
      end
      StWrResp: begin
        bready_d = 1'b1;
        if (m_axil_bvalid) begin
          bready_d = 1'b0;
          state_d  = StDone;
          ready_d  = 1'b1;
          error_d  = (m_axil_bresp != RespOkay);
        end
      end
      StRdAddr: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        rready_d = 1'b1;
        if (m_axil_rvalid) begin
          rready_d = 1'b0;
          rdata_d  = m_axil_rdata;
          state_d  = StDone;
          ready_d  = 1'b1;
          error_d  = (m_axil_rresp != RespOkay);
        end
      end
      StDone: begin
        // mem_valid is deliberately ignored here so a held request is not replayed.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      instr_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      instr_q   <= instr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      rdata_q   <= rdata_d;
    end
  end

  // Port mapping; address and strobes pass through untouched.
  always_comb begin
    mem_ready      = ready_q;
    mem_rdata      = rdata_q;
    mem_error      = error_q;
    m_axil_awaddr  = addr_q;
    m_axil_awprot  = ProtData;
    m_axil_awvalid = awvalid_q;
    m_axil_wdata   = wdata_q;
    m_axil_wstrb   = wstrb_q;
    m_axil_wvalid  = wvalid_q;
    m_axil_bready  = bready_q;
    m_axil_araddr  = addr_q;
    m_axil_arprot  = rd_prot(instr_q);
    m_axil_arvalid = arvalid_q;
    m_axil_rready  = rready_q;
  end

endmodule

// File: tb/tb_cpu_axil_master.sv
// Randomized bench: CPU-side driver plus a behavioural AXI-Lite slave.
module tb_cpu_axil_master;
  import cpu_axil_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, mem_error;
  logic [31:0] mem_rdata;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
  logic        m_axil_awready = 1'b0, m_axil_wready = 1'b0, m_axil_arready = 1'b0;
  logic        m_axil_bvalid = 1'b0, m_axil_rvalid = 1'b0;
  logic [1:0]  m_axil_bresp = '0, m_axil_rresp = '0;
  logic [31:0] m_axil_rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  // Slave behaviour: 0 always ready, 1 random, 2 awready trails wready, 3 stalled.
  int          mode = 0;
  logic [31:0] next_rdata = '0;
  logic [1:0]  next_resp = '0;
  bit aw_seen, w_seen, ar_seen, aw_hs, w_hs, ar_hs, b_hs, r_hs, prev_rst = 1'b1;
  bit p_awvalid, p_wvalid, p_arvalid, w_before_aw, split;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [2:0]  p_awprot, p_arprot;
  logic [3:0]  p_wstrb;
  int b_wait, r_wait, w_age, bready_cnt, cap_aw_n, cap_w_n, cap_ar_n;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [2:0]  cap_awprot, cap_arprot;
  logic [3:0]  cap_wstrb;

  cpu_axil_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .STRB_WIDTH(4)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .mem_valid      (mem_valid),
    .mem_instr      (mem_instr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .mem_error      (mem_error),
    .m_axil_awaddr  (m_axil_awaddr),
    .m_axil_awprot  (m_axil_awprot),
    .m_axil_awvalid (m_axil_awvalid),
    .m_axil_awready (m_axil_awready),
    .m_axil_wdata   (m_axil_wdata),
    .m_axil_wstrb   (m_axil_wstrb),
    .m_axil_wvalid  (m_axil_wvalid),
    .m_axil_wready  (m_axil_wready),
    .m_axil_bresp   (m_axil_bresp),
    .m_axil_bvalid  (m_axil_bvalid),
    .m_axil_bready  (m_axil_bready),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arprot  (m_axil_arprot),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready)
  );

  always #5 aclk = ~aclk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int resp_delay();
    return (mode == 1) ? int'($urandom_range(0, 3)) : 0;
  endfunction

  // Slave acts on falling edges: retire last edge's handshakes, check, then drive.
  always @(negedge aclk) begin
    if (!aresetn) begin
      m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_arready = 1'b0;
      m_axil_bvalid = 1'b0; m_axil_rvalid = 1'b0;
      aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0; split = 1'b0;
      aw_hs = 1'b0; w_hs = 1'b0; ar_hs = 1'b0; b_hs = 1'b0; r_hs = 1'b0;
      p_awvalid = 1'b0; p_wvalid = 1'b0; p_arvalid = 1'b0;
      prev_rst = 1'b1;
    end else begin
      if (b_hs) begin m_axil_bvalid = 1'b0; aw_seen = 1'b0; w_seen = 1'b0; split = 1'b0; end
      if (r_hs) begin m_axil_rvalid = 1'b0; ar_seen = 1'b0; end
      if (aw_hs) begin
        aw_seen = 1'b1; cap_aw_n++; cap_awaddr = p_awaddr; cap_awprot = p_awprot;
        w_before_aw = w_seen; bready_cnt = 0; b_wait = resp_delay();
      end
      if (w_hs) begin
        w_seen = 1'b1; cap_w_n++; cap_wdata = p_wdata; cap_wstrb = p_wstrb;
        w_age = 0; b_wait = resp_delay();
      end
      if (ar_hs) begin
        ar_seen = 1'b1; cap_ar_n++; cap_araddr = p_araddr; cap_arprot = p_arprot;
        r_wait = resp_delay();
      end
      // A valid without its handshake must persist with an unchanged payload.
      if (!prev_rst) begin
        if (p_awvalid && !aw_hs)
          chk_eq("aw_hold", 64'({m_axil_awvalid, m_axil_awprot, m_axil_awaddr}),
                 64'({1'b1, p_awprot, p_awaddr}));
        if (p_wvalid && !w_hs)
          chk_eq("w_hold", 64'({m_axil_wvalid, m_axil_wstrb, m_axil_wdata}),
                 64'({1'b1, p_wstrb, p_wdata}));
        if (p_arvalid && !ar_hs)
          chk_eq("ar_hold", 64'({m_axil_arvalid, m_axil_arprot, m_axil_araddr}),
                 64'({1'b1, p_arprot, p_araddr}));
      end
      chk_eq("bready_window", 64'(m_axil_bready), 64'(aw_seen && w_seen));
      chk_eq("rready_window", 64'(m_axil_rready), 64'(ar_seen));
      if (m_axil_bready) bready_cnt++;
      if (m_axil_awvalid && !m_axil_wvalid) split = 1'b1;
      case (mode)
        0: begin m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_arready = 1'b1; end
        1: begin
          m_axil_awready = 1'($urandom_range(0, 1));
          m_axil_wready  = 1'($urandom_range(0, 1));
          m_axil_arready = 1'($urandom_range(0, 1));
        end
        2: begin
          m_axil_wready = 1'b1; m_axil_arready = 1'b1;
          m_axil_awready = w_seen && (w_age >= 1);
        end
        default: begin m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_arready = 1'b0; end
      endcase
      if (aw_seen && w_seen && !m_axil_bvalid) begin
        if (b_wait == 0) begin m_axil_bvalid = 1'b1; m_axil_bresp = next_resp; end
        else b_wait--;
      end
      if (ar_seen && !m_axil_rvalid) begin
        if (r_wait == 0) begin
          m_axil_rvalid = 1'b1; m_axil_rdata = next_rdata; m_axil_rresp = next_resp;
        end else r_wait--;
      end
      if (w_seen && !aw_seen) w_age++;
      aw_hs = m_axil_awvalid && m_axil_awready;
      w_hs  = m_axil_wvalid && m_axil_wready;
      ar_hs = m_axil_arvalid && m_axil_arready;
      b_hs  = m_axil_bvalid && m_axil_bready;
      r_hs  = m_axil_rvalid && m_axil_rready;
      p_awvalid = m_axil_awvalid; p_awaddr = m_axil_awaddr; p_awprot = m_axil_awprot;
      p_wvalid = m_axil_wvalid; p_wdata = m_axil_wdata; p_wstrb = m_axil_wstrb;
      p_arvalid = m_axil_arvalid; p_araddr = m_axil_araddr; p_arprot = m_axil_arprot;
      prev_rst = 1'b0;
    end
  end

  // One CPU request; exp_lat = 0 skips the latency check.
  task automatic do_req(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] rd, input logic [1:0] resp,
                        input int exp_lat);
    int lat;
    bit got;
    next_rdata = rd; next_resp = resp;
    cap_aw_n = 0; cap_w_n = 0; cap_ar_n = 0;
    mem_valid = 1'b1; mem_instr = instr; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
    lat = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(posedge aclk); #1;
      lat++;
      got = mem_ready;
    end
    mem_valid = 1'b0;
    chk_eq("ready_seen", 64'(got), 64'd1);
    if (!got) return;
    if (exp_lat > 0) chk_eq("latency", 64'(lat), 64'(exp_lat));
    chk_eq("mem_error", 64'(mem_error), 64'(resp != 2'b00));
    if (strb == 4'b0) begin
      chk_eq("mem_rdata", 64'(mem_rdata), 64'(rd));
      chk_eq("ar_count", 64'(cap_ar_n), 64'd1);
      chk_eq("wr_count", 64'(cap_aw_n + cap_w_n), 64'd0);
      chk_eq("araddr", 64'(cap_araddr), 64'(addr));
      chk_eq("arprot", 64'(cap_arprot), 64'({instr, 2'b00}));
    end else begin
      chk_eq("aw_count", 64'(cap_aw_n), 64'd1);
      chk_eq("w_count", 64'(cap_w_n), 64'd1);
      chk_eq("rd_count", 64'(cap_ar_n), 64'd0);
      chk_eq("awaddr", 64'(cap_awaddr), 64'(addr));
      chk_eq("awprot", 64'(cap_awprot), 64'd0);
      chk_eq("wdata", 64'(cap_wdata), 64'(wdata));
      chk_eq("wstrb", 64'(cap_wstrb), 64'(strb));
    end
  endtask

  // One quiet cycle; also proves mem_ready was a single-cycle pulse.
  task automatic idle_cycle();
    mem_valid = 1'b0;
    @(posedge aclk); #1;
    chk_eq("ready_pulse", 64'(mem_ready), 64'd0);
  endtask

  initial begin
    logic [3:0] strb;
    logic [1:0] resp;
    logic       instr;
    repeat (3) @(posedge aclk);
    #1;
    chk_eq("rst_awvalid", 64'(m_axil_awvalid), 64'd0);
    chk_eq("rst_wvalid", 64'(m_axil_wvalid), 64'd0);
    chk_eq("rst_bready", 64'(m_axil_bready), 64'd0);
    chk_eq("rst_arvalid", 64'(m_axil_arvalid), 64'd0);
    chk_eq("rst_rready", 64'(m_axil_rready), 64'd0);
    chk_eq("rst_mem_ready", 64'(mem_ready), 64'd0);
    chk_eq("rst_mem_error", 64'(mem_error), 64'd0);
    chk_eq("rst_mem_rdata", 64'(mem_rdata), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Always-ready slave: fixed three-cycle latency both ways.
    mode = 0;
    do_req(1'b0, 32'h100, 32'h0, 4'b0, 32'hDEADBEEF, RespOkay, 3);
    idle_cycle();
    do_req(1'b0, 32'h104, 32'h0, 4'b0, 32'hFFFFFFFF, RespSlverr, 3);
    idle_cycle();
    do_req(1'b1, 32'h0, 32'h0, 4'b0, 32'h00000013, RespOkay, 3);
    idle_cycle();
    do_req(1'b0, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, RespOkay, 3);
    idle_cycle();

    // Back-to-back: the follow-on request is presented during DONE.
    do_req(1'b0, 32'h200, 32'h0, 4'b0, 32'h11223344, RespOkay, 3);
    do_req(1'b0, 32'h208, 32'hA5A5A5A5, 4'b1100, 32'h0, RespDecerr, 4);
    idle_cycle();

    // awready trails the W handshake by two cycles.
    mode = 2;
    do_req(1'b0, 32'h204, 32'h12345678, 4'b0011, 32'h0, RespOkay, 5);
    chk_eq("w_first", 64'(w_before_aw), 64'd1);
    chk_eq("wvalid_drops_first", 64'(split), 64'd1);
    chk_eq("bready_cycles", 64'(bready_cnt), 64'd1);
    idle_cycle();

    // Randomized traffic against a randomly stalling slave.
    for (int i = 0; i < 60; i++) begin
      mode  = (i % 4 == 0) ? 0 : 1;
      strb  = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RespOkay;
      instr = (strb == 4'b0) && ($urandom_range(0, 1) == 1);
      do_req(instr, $urandom, $urandom, strb, $urandom, resp, (mode == 0) ? 3 : 0);
      idle_cycle();
    end

    // Reset while AR waits for arready abandons the transaction.
    mode = 3;
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h300; mem_wstrb = 4'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk_eq("stall_arvalid", 64'(m_axil_arvalid), 64'd1);
    aresetn = 1'b0;
    mem_valid = 1'b0;
    @(posedge aclk); #1;
    chk_eq("abort_arvalid", 64'(m_axil_arvalid), 64'd0);
    chk_eq("abort_rready", 64'(m_axil_rready), 64'd0);
    chk_eq("abort_ready", 64'(mem_ready), 64'd0);
    aresetn = 1'b1;
    mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge aclk); #1;
      chk_eq("abort_no_ready", 64'(mem_ready), 64'd0);
    end
    do_req(1'b0, 32'h300, 32'h0, 4'b0, 32'h0BADF00D, RespOkay, 3);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
